// File: rtl/switch_ingress_arbiter.sv
// switch_ingress_arbiter: per-lane FIFOs feeding per-output round-robin
// arbitration so the downstream switch never sees two lanes on one output.
module switch_ingress_arbiter #(
  parameter int PORTS  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PORTS-1:0]         src_valid,
  output logic [PORTS-1:0]         src_ready,
  input  logic [PORTS*DATA_W-1:0]  src_data,
  input  logic [PORTS*ADDR_W-1:0]  src_addr,
  output logic [PORTS-1:0]         valid_in,
  output logic [PORTS*DATA_W-1:0]  data_in,
  output logic [PORTS*ADDR_W-1:0]  addr_in,
  output logic [PORTS-1:0]         drop,
  output logic [15:0]              conflict_cnt
);

  localparam int PW = $clog2(PORTS);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_data [PORTS][DEPTH];
  logic [PW-1:0]     r_dst  [PORTS][DEPTH];
  logic [AW-1:0]     r_wp   [PORTS];
  logic [AW-1:0]     r_rp   [PORTS];
  logic [AW:0]       r_cnt  [PORTS];
  logic [PW-1:0]     r_rr   [PORTS];
  logic              r_en;

  logic [PORTS-1:0]        r_valid;
  logic [PORTS*DATA_W-1:0] r_dout;
  logic [PORTS*ADDR_W-1:0] r_aout;
  logic [PORTS-1:0]        r_drop;
  logic [15:0]             r_ccnt;

  logic [PORTS-1:0]  w_ok;
  logic [PORTS-1:0]  w_acc;
  logic [PORTS-1:0]  w_push;
  logic [PORTS-1:0]  w_req;
  logic [PORTS-1:0]  w_gnt;
  logic [PW-1:0]     w_hdst [PORTS];
  logic [DATA_W-1:0] w_hdat [PORTS];
  logic [PW-1:0]     w_rr_nxt [PORTS];
  logic              w_conf;

  // Handshake, address check and FIFO head view per lane
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      src_ready[i] = r_en && (r_cnt[i] < (AW+1)'(DEPTH));
      w_ok[i]      = src_addr[i*ADDR_W +: ADDR_W] < ADDR_W'(PORTS);
      w_acc[i]     = src_valid[i] & src_ready[i];
      w_push[i]    = w_acc[i] & w_ok[i];
      w_req[i]     = r_cnt[i] != '0;
      w_hdst[i]    = r_dst[i][r_rp[i]];
      w_hdat[i]    = r_data[i][r_rp[i]];
    end
  end

  // Per-output round-robin search starting at r_rr[o]
  always_comb begin : arb
    logic [PW-1:0] idx;
    logic          found;
    int            ncand;
    w_gnt  = '0;
    w_conf = 1'b0;
    idx    = '0;
    found  = 1'b0;
    ncand  = 0;
    for (int o = 0; o < PORTS; o++) begin
      w_rr_nxt[o] = r_rr[o];
    end
    for (int o = 0; o < PORTS; o++) begin
      found = 1'b0;
      ncand = 0;
      for (int j = 0; j < PORTS; j++) begin
        idx = r_rr[o] + PW'(j);
        if (w_req[idx] && (w_hdst[idx] == PW'(o))) begin
          ncand = ncand + 1;
          if (!found) begin
            found       = 1'b1;
            w_gnt[idx]  = 1'b1;
            w_rr_nxt[o] = idx + PW'(1);
          end
        end
      end
      if (ncand >= 2) w_conf = 1'b1;
    end
  end

  // FIFO pointers, occupancy, rr state and ready enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en <= 1'b0;
      for (int i = 0; i < PORTS; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
        r_rr[i]  <= '0;
      end
    end else begin
      r_en <= 1'b1;
      for (int i = 0; i < PORTS; i++) begin
        r_rr[i] <= w_rr_nxt[i];
        if (w_push[i]) r_wp[i] <= r_wp[i] + AW'(1);
        if (w_gnt[i])  r_rp[i] <= r_rp[i] + AW'(1);
        if (w_push[i] && !w_gnt[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_push[i] && w_gnt[i])
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // FIFO storage; contents only matter once counted as valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (w_push[i]) begin
        r_data[i][r_wp[i]] <= src_data[i*DATA_W +: DATA_W];
        r_dst[i][r_wp[i]]  <= src_addr[i*ADDR_W +: PW];
      end
    end
  end

  // Registered switch-side outputs, drop pulses and conflict counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_dout  <= '0;
      r_aout  <= '0;
      r_drop  <= '0;
      r_ccnt  <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        r_valid[i] <= w_gnt[i];
        r_dout[i*DATA_W +: DATA_W] <= w_gnt[i] ? w_hdat[i] : '0;
        r_aout[i*ADDR_W +: ADDR_W] <= w_gnt[i] ? ADDR_W'(w_hdst[i]) : '0;
        r_drop[i] <= w_acc[i] & ~w_ok[i];
      end
      if (w_conf && (r_ccnt != 16'hFFFF)) r_ccnt <= r_ccnt + 16'd1;
    end
  end

  assign valid_in     = r_valid;
  assign data_in      = r_dout;
  assign addr_in      = r_aout;
  assign drop         = r_drop;
  assign conflict_cnt = r_ccnt;

endmodule

// File: tb/tb_switch_ingress_arbiter.sv
// tb_switch_ingress_arbiter: directed checks of buffering, arbitration,
// drop handling and reset behaviour.
module tb_switch_ingress_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic [31:0] src_data;
  logic [31:0] src_addr;
  logic [3:0]  valid_in;
  logic [31:0] data_in;
  logic [31:0] addr_in;
  logic [3:0]  drop;
  logic [15:0] conflict_cnt;

  int n_tot = 0;
  int n_bad = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         last;
  int         rdy_edges;

  always #5 clk = ~clk;

  switch_ingress_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_data     (src_data),
    .src_addr     (src_addr),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .addr_in      (addr_in),
    .drop         (drop),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic idle();
    src_valid = '0;
    src_data  = '0;
    src_addr  = '0;
  endtask

  task automatic observe(input bit alt);
    logic [7:0] d;
    int         lane;
    if (valid_in != 4'b0000) begin
      check("s_lane", 32'(valid_in == 4'b0001 || valid_in == 4'b0010), 1);
      lane = (valid_in == 4'b0001) ? 0 : 1;
      if (alt && last >= 0) check("s_alt", 32'(lane == last), 0);
      last = lane;
      if (lane == 0) begin
        check("s_q0", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
          d = q0.pop_front();
          check("s_d0", data_in, {24'h0, d});
          check("s_a0", addr_in, 32'h3);
        end
      end else begin
        check("s_q1", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          d = q1.pop_front();
          check("s_d1", data_in, {16'h0, d, 8'h0});
          check("s_a1", addr_in, 32'h300);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] nv0;
    logic [7:0] nv1;
    logic [1:0] acc;
    logic       prev_r0;
    idle();
    reset = 1'b0;
    #12;
    check("rst_valid", 32'(valid_in), 0);
    check("rst_data", data_in, 0);
    check("rst_addr", addr_in, 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_ready", 32'(src_ready), 0);
    check("rst_cnt", 32'(conflict_cnt), 0);
    nx();
    reset = 1'b1;
    nx();
    check("rel_ready", 32'(src_ready), 32'hF);
    check("rel_valid", 32'(valid_in), 0);
    nx();
    check("idle_valid", 32'(valid_in), 0);

    // single packet lane 2 -> output 1
    src_valid = 4'b0100;
    src_data  = 32'h00A50000;
    src_addr  = 32'h00010000;
    nx();
    idle();
    check("p_early", 32'(valid_in), 0);
    nx();
    check("p_valid", 32'(valid_in), 32'h4);
    check("p_data", data_in, 32'h00A50000);
    check("p_addr", addr_in, 32'h00010000);
    nx();
    check("p_once", 32'(valid_in), 0);

    // lanes 0 and 3 collide on output 2
    src_valid = 4'b1001;
    src_data  = 32'h33000011;
    src_addr  = 32'h02000002;
    nx();
    idle();
    nx();
    check("c1_valid", 32'(valid_in), 32'h1);
    check("c1_data", data_in, 32'h11);
    check("c1_addr", addr_in, 32'h2);
    check("c1_cnt", 32'(conflict_cnt), 1);
    nx();
    check("c2_valid", 32'(valid_in), 32'h8);
    check("c2_data", data_in, 32'h33000000);
    check("c2_addr", addr_in, 32'h02000000);
    check("c2_cnt", 32'(conflict_cnt), 1);
    nx();
    // lane 0 alone moves rr[2] to 1
    src_valid = 4'b0001;
    src_data  = 32'h22;
    src_addr  = 32'h2;
    nx();
    idle();
    nx();
    check("c3_valid", 32'(valid_in), 32'h1);
    nx();
    src_valid = 4'b1001;
    src_data  = 32'h55000044;
    src_addr  = 32'h02000002;
    nx();
    idle();
    nx();
    check("c4_valid", 32'(valid_in), 32'h8);
    check("c4_data", data_in, 32'h55000000);
    check("c4_cnt", 32'(conflict_cnt), 2);
    nx();
    check("c5_valid", 32'(valid_in), 32'h1);
    check("c5_data", data_in, 32'h44);
    check("c5_cnt", 32'(conflict_cnt), 2);
    nx();

    // lanes 0 and 1 stream to output 3
    nv0 = 8'h00;
    nv1 = 8'h80;
    acc = 2'b00;
    last = -1;
    rdy_edges = 0;
    prev_r0 = src_ready[0];
    for (int c = 0; c < 24; c++) begin
      if (c == 2) check("s_first", 32'(valid_in), 32'h1);
      if (c >= 2) check("s_busy", 32'(valid_in != 4'b0000), 1);
      observe(c >= 2);
      if (acc[0]) nv0 = nv0 + 8'd1;
      if (acc[1]) nv1 = nv1 + 8'd1;
      src_valid = 4'b0011;
      src_data  = {16'h0, nv1, nv0};
      src_addr  = 32'h00000303;
      acc = src_ready[1:0];
      if (acc[0]) q0.push_back(nv0);
      if (acc[1]) q1.push_back(nv1);
      if (src_ready[0] != prev_r0) rdy_edges++;
      prev_r0 = src_ready[0];
      nx();
    end
    idle();
    for (int c = 0; c < 30; c++) begin
      observe(1'b0);
      nx();
    end
    check("s_left0", q0.size(), 0);
    check("s_left1", q1.size(), 0);
    check("s_toggle", 32'(rdy_edges >= 2), 1);
    check("s_ready", 32'(src_ready), 32'hF);

    // bad address on lane 0
    check("d_rdy0", 32'(src_ready[0]), 1);
    src_valid = 4'b0001;
    src_data  = 32'h5A;
    src_addr  = 32'h7;
    nx();
    idle();
    check("d_drop", 32'(drop), 32'h1);
    check("d_valid", 32'(valid_in), 0);
    check("d_rdy", 32'(src_ready[0]), 1);
    nx();
    check("d_once", 32'(drop), 0);
    check("d_none", 32'(valid_in), 0);
    nx();
    check("d_none2", 32'(valid_in), 0);

    // queue traffic then reset mid-cycle
    for (int c = 0; c < 3; c++) begin
      src_valid = 4'b1111;
      src_data  = 32'h63626160 + 32'(c);
      src_addr  = 32'h0;
      nx();
    end
    idle();
    #2;
    reset = 1'b0;
    #1;
    check("mr_valid", 32'(valid_in), 0);
    check("mr_data", data_in, 0);
    check("mr_addr", addr_in, 0);
    check("mr_ready", 32'(src_ready), 0);
    check("mr_cnt", 32'(conflict_cnt), 0);
    check("mr_drop", 32'(drop), 0);
    nx();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      nx();
      check("mr_quiet", 32'(valid_in), 0);
    end
    check("mr_rdy", 32'(src_ready), 32'hF);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
